// File: rtl/dft_wb_pkg.sv
// dft_wb_pkg: register map, FSM states and frame size shared by the DFT Wishbone host
package dft_wb_pkg;
  localparam int N_POINTS = 32;
  localparam logic [7:0] NEXT        = 8'h00;
  localparam logic [7:0] DATAW       = 8'h04;
  localparam logic [7:0] WADDR       = 8'h08;
  localparam logic [7:0] WLO         = 8'h0C;
  localparam logic [7:0] WHI         = 8'h10;
  localparam logic [7:0] RADDR_VALID = 8'h14;
  localparam logic [7:0] RLO         = 8'h20;
  localparam logic [7:0] RHI         = 8'h24;
  typedef enum logic [2:0] {IDLE, LD_WAIT, LD_BUS, KICK, POLL, SETTLE, RD_BUS, RD_OUT} state_e;
endpackage

// File: rtl/wb_single_xfer.sv
// wb_single_xfer: one registered Wishbone classic read or write, released the cycle after ack/err
module wb_single_xfer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdat_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);
  logic cyc_q, we_q, fin;
  logic [31:0] adr_q, dat_q;
  assign fin = cyc_q & (wbm_ack_i | wbm_err_i);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (fin) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
    end else if (req_i && !cyc_q) begin
      cyc_q <= 1'b1;
      we_q  <= we_i;
      adr_q <= adr_i;
      dat_q <= wdat_i;
    end
  assign busy_o    = cyc_q;
  assign done_o    = fin;
  assign err_o     = cyc_q & wbm_err_i;
  assign rdat_o    = wbm_dat_i;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
endmodule

// File: rtl/dft_wb_host.sv
// dft_wb_host: Wishbone initiator streaming a 32-point frame through the DFT slave and back
module dft_wb_host
  import dft_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          POLL_TIMEOUT  = 4096,
  parameter int          SETTLE_CYCLES = 40
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic [63:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [63:0] out_data_o,
  output logic [4:0]  out_idx_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);
  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_e state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [2:0] step_q, step_d;
  logic [63:0] word_q, word_d, rdat_q, rdat_d;
  logic err_q, err_d, done_q, done_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [SW-1:0] settle_q, settle_d;
  logic x_req, x_we, x_busy, x_done, x_err, last;
  logic [7:0] x_off;
  logic [31:0] x_wdat, x_rdat;
  assign last = idx_q == 5'(N_POINTS - 1);
  // Address/data of the transfer for the current state and step
  always_comb begin
    x_we = 1'b1;
    x_off = NEXT;
    x_wdat = '0;
    case (state_q)
      LD_BUS: begin
        x_off = step_q == 3'd0 ? WADDR : step_q == 3'd1 ? WLO : step_q == 3'd2 ? WHI : DATAW;
        x_wdat = step_q == 3'd0 ? {27'b0, idx_q} : step_q == 3'd1 ? word_q[31:0] :
                 step_q == 3'd2 ? word_q[63:32] : {31'b0, step_q == 3'd3};
      end
      KICK: x_wdat = {31'b0, step_q == 3'd0};
      POLL: begin
        x_we = 1'b0;
        x_off = RADDR_VALID;
      end
      RD_BUS: begin
        x_we = step_q == 3'd0;
        x_off = step_q == 3'd0 ? RADDR_VALID : step_q == 3'd1 ? RLO : RHI;
        x_wdat = {27'b0, idx_q};
      end
      default: ;
    endcase
  end
  assign x_req = (state_q inside {LD_BUS, KICK, POLL, RD_BUS}) & ~x_busy;
  wb_single_xfer u_xfer (
    .clk_i(wb_clk_i), .rst_ni(wb_rst_ni), .req_i(x_req), .we_i(x_we),
    .adr_i(BASE_ADDR + {24'b0, x_off}), .wdat_i(x_wdat),
    .busy_o(x_busy), .done_o(x_done), .err_o(x_err), .rdat_o(x_rdat),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    step_d = step_q;
    word_d = word_q;
    rdat_d = rdat_q;
    err_d = err_q;
    done_d = 1'b0;
    poll_d = poll_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: if (start_i) begin
        err_d = 1'b0;
        idx_d = '0;
        state_d = LD_WAIT;
      end
      LD_WAIT: if (in_valid_i) begin
        word_d = in_data_i;
        step_d = '0;
        state_d = LD_BUS;
      end
      LD_BUS: if (x_done) begin
        step_d = step_q == 3'd4 ? 3'd0 : step_q + 3'd1;
        state_d = step_q != 3'd4 ? LD_BUS : last ? KICK : LD_WAIT;
        idx_d = step_q == 3'd4 && !last ? idx_q + 5'd1 : idx_q;
      end
      KICK: if (x_done) begin
        step_d = step_q == 3'd1 ? 3'd0 : step_q + 3'd1;
        state_d = step_q == 3'd1 ? POLL : KICK;
        poll_d = '0;
      end
      POLL: if (x_done) begin
        poll_d = poll_q + PW'(1);
        settle_d = '0;
        state_d = x_rdat[0] ? SETTLE : poll_d == PW'(POLL_TIMEOUT) ? IDLE : POLL;
        err_d = !x_rdat[0] && poll_d == PW'(POLL_TIMEOUT);
      end
      SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          idx_d = '0;
          step_d = '0;
          state_d = RD_BUS;
        end
      end
      RD_BUS: if (x_done) begin
        rdat_d = step_q == 3'd1 ? {rdat_q[63:32], x_rdat} :
                 step_q == 3'd2 ? {x_rdat, rdat_q[31:0]} : rdat_q;
        step_d = step_q == 3'd2 ? 3'd0 : step_q + 3'd1;
        state_d = step_q == 3'd2 ? RD_OUT : RD_BUS;
      end
      RD_OUT: if (out_ready_i) begin
        done_d = last;
        idx_d = last ? idx_q : idx_q + 5'd1;
        state_d = last ? IDLE : RD_BUS;
      end
      default: ;
    endcase
    // A bus error anywhere abandons the frame
    if (x_err) begin
      state_d = IDLE;
      step_d = '0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      idx_q <= '0;
      step_q <= '0;
      word_q <= '0;
      rdat_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      poll_q <= '0;
      settle_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      step_q <= step_d;
      word_q <= word_d;
      rdat_q <= rdat_d;
      err_q <= err_d;
      done_q <= done_d;
      poll_q <= poll_d;
      settle_q <= settle_d;
    end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign err_o = err_q;
  assign in_ready_o = state_q == LD_WAIT;
  assign out_valid_o = state_q == RD_OUT;
  assign out_data_o = rdat_q;
  assign out_idx_o = idx_q;
  assign wbm_sel_o = 4'hF;
endmodule

// File: tb/tb_dft_wb_host.sv
// tb_dft_wb_host: directed checks of the DFT Wishbone host against a behavioural DFT slave
`timescale 1ns/1ps
module tb_dft_wb_host;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0, out_data;
  logic busy, done, err, in_ready, out_valid, we, cyc, stb, ack, berr;
  logic [4:0] out_idx;
  logic [31:0] adr, wdat, rdat;
  logic [3:0] sel;
  dft_wb_host dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_idx_o(out_idx), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_ack_i(ack), .wbm_err_i(berr)
  );
  // Second host with a short poll limit against a slave whose data_valid never rises
  logic start2 = 1'b0;
  logic busy2, done2, err2, in_ready2, out_valid2, we2, cyc2, stb2;
  logic [63:0] out_data2;
  logic [4:0] out_idx2;
  logic [31:0] adr2, wdat2;
  logic [3:0] sel2;
  dft_wb_host #(.POLL_TIMEOUT(8)) dut2 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start2), .busy_o(busy2), .done_o(done2), .err_o(err2),
    .in_data_i(64'h0), .in_valid_i(1'b1), .in_ready_o(in_ready2),
    .out_data_o(out_data2), .out_idx_o(out_idx2), .out_valid_o(out_valid2), .out_ready_i(1'b1),
    .wbm_adr_o(adr2), .wbm_dat_o(wdat2), .wbm_dat_i(32'h0), .wbm_sel_o(sel2), .wbm_we_o(we2),
    .wbm_cyc_o(cyc2), .wbm_stb_o(stb2), .wbm_ack_i(cyc2 & stb2), .wbm_err_i(1'b0)
  );
  logic [63:0] mem [32];
  logic [4:0] s_waddr = '0, s_raddr = '0;
  logic [31:0] s_lo = '0, s_hi = '0;
  int s_cnt = -1;
  logic s_dv = 1'b0;
  bit inj = 1'b0;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} xfer_t;
  xfer_t log_q[$];
  assign berr = cyc & stb & inj & we & (adr == 32'h10) & (s_waddr == 5'd7);
  assign ack = cyc & stb & ~berr;
  always_comb rdat = adr == 32'h14 ? {31'b0, s_dv} : adr == 32'h20 ? ~mem[s_raddr][31:0] :
                     adr == 32'h24 ? ~mem[s_raddr][63:32] : 32'h0;
  always @(posedge clk) begin
    if (s_cnt > 0) s_cnt <= s_cnt - 1;
    else if (s_cnt == 0) begin
      s_dv <= 1'b1;
      s_cnt <= -1;
    end
    if (ack) begin
      log_q.push_back(xfer_t'{we, adr, we ? wdat : rdat});
      if (we)
        case (adr)
          32'h08: s_waddr <= wdat[4:0];
          32'h0C: s_lo <= wdat;
          32'h10: s_hi <= wdat;
          32'h04: if (wdat == 32'd1) mem[s_waddr] <= {s_hi, s_lo};
          32'h00: if (wdat == 32'd1) begin
            s_dv <= 1'b0;
            s_cnt <= 49;
          end
          32'h14: s_raddr <= wdat[4:0];
          default: ;
        endcase
    end
  end
  int done_cnt = 0, viol = 0, unstable = 0, rd2 = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [63:0] pd = '0;
  always @(negedge clk)
    if (rst_n) begin
      if (done) done_cnt++;
      if ((in_ready | out_valid) & cyc) viol++;
      if (pv & ~pr & (~out_valid | (out_data != pd))) unstable++;
      if (cyc2 & stb2 & ~we2 & (adr2 == 32'h14)) rd2++;
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end else pv = 1'b0;
  int pass_cnt = 0, tot = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  task automatic fail(input string nm);
    tot++;
    $display("FAIL %s: wait bound expired", nm);
  endtask
  function automatic logic [63:0] samp(input int k);
    return {16'(k + 3), 16'(k + 2), 16'(k + 1), 16'(k)};
  endfunction
  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic send(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      in_valid = 1'b0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      in_data = samp(k);
      in_valid = 1'b1;
      do begin @(negedge clk); t++; end while (!in_ready && t < 3000);
      if (!in_ready) begin
        fail("in_handshake");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask
  task automatic recv(input int n, input int stall);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      out_ready = (stall == 0);
      do begin @(negedge clk); t++; end while (!out_valid && t < 3000);
      if (!out_valid) begin
        fail("out_handshake");
        return;
      end
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
      end
      check($sformatf("out_idx%0d", k), 64'(out_idx), 64'(k));
      check($sformatf("out_data%0d", k), out_data, ~samp(k));
      @(posedge clk); #1;
    end
  endtask
  task automatic frame_end(input string nm, input int d0);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({nm, "_err_busy"}, {62'b0, err, busy}, 64'd0);
  endtask
  typedef struct {int pos; logic [48:0] v;} ord_t;
  ord_t ord[10];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end
  initial begin
    int d0, t;
    ord[0] = '{0,   {1'b1, 16'h08, 32'h0}};
    ord[1] = '{1,   {1'b1, 16'h0C, 32'h0001_0000}};
    ord[2] = '{2,   {1'b1, 16'h10, 32'h0003_0002}};
    ord[3] = '{3,   {1'b1, 16'h04, 32'h1}};
    ord[4] = '{4,   {1'b1, 16'h04, 32'h0}};
    ord[5] = '{5,   {1'b1, 16'h08, 32'h1}};
    ord[6] = '{159, {1'b1, 16'h04, 32'h0}};
    ord[7] = '{160, {1'b1, 16'h00, 32'h1}};
    ord[8] = '{161, {1'b1, 16'h00, 32'h0}};
    ord[9] = '{162, {1'b0, 16'h14, 32'h0}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {56'b0, busy, done, err, in_ready, out_valid, cyc, stb, we}, 64'd0);
    check("rst_bus", {adr, wdat}, 64'd0);
    check("rst_out", out_data, 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    // happy path and exact bus order
    log_q.delete();
    d0 = done_cnt;
    pulse_start();
    send(32, 0);
    recv(32, 0);
    frame_end("happy", d0);
    for (int i = 0; i < 10; i++)
      if (log_q.size() > ord[i].pos)
        check($sformatf("order%0d", ord[i].pos),
              {15'b0, log_q[ord[i].pos].we, log_q[ord[i].pos].adr[15:0], log_q[ord[i].pos].dat}, 64'(ord[i].v));
      else fail($sformatf("order%0d", ord[i].pos));
    // backpressure on both streams
    d0 = done_cnt;
    pulse_start();
    send(32, 20);
    recv(32, 10);
    frame_end("stall", d0);
    // bus error on the high-word write of word 7
    inj = 1'b1;
    d0 = done_cnt;
    pulse_start();
    send(8, 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!(cyc & berr) && t < 100);
    if (!(cyc & berr)) fail("berr_seen");
    else begin
      @(negedge clk);
      check("berr_release", {60'b0, cyc, stb, err, busy}, 64'b0010);
    end
    repeat (5) @(posedge clk);
    #1;
    check("berr_nodone", 64'(done_cnt - d0), 64'd0);
    inj = 1'b0;
    d0 = done_cnt;
    pulse_start();
    check("berr_clear", {62'b0, err, busy}, 64'b01);
    send(32, 0);
    recv(32, 0);
    frame_end("recover", d0);
    // poll timeout on the second host
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!err2 && t < 3000);
    if (!err2) fail("timeout_err");
    @(negedge clk);
    check("timeout_polls", 64'(rd2), 64'd8);
    check("timeout_state", {62'b0, err2, busy2}, 64'b10);
    // reset during readback of word 12
    pulse_start();
    send(32, 0);
    recv(12, 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!cyc && t < 100);
    if (!cyc) fail("rst_rdbus");
    check("rst_mid_idx", 64'(out_idx), 64'd12);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_ctl", {56'b0, busy, done, err, in_ready, out_valid, cyc, stb, we}, 64'd0);
    check("rstmid_bus", {adr, wdat}, 64'd0);
    check("rstmid_out", {out_data[58:0], out_idx}, 64'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    d0 = done_cnt;
    pulse_start();
    send(32, 0);
    recv(32, 0);
    frame_end("after_rst", d0);
    check("no_bus_while_stalled", 64'(viol), 64'd0);
    check("out_stable", 64'(unstable), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
